// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle: raw sensor and accept enable in, money code and status out.
// The slave modport is the acceptor itself; the master modport is whoever drives the slot.
interface coin_acceptor_if;
  logic       coin_sensor;
  logic       accept_en;
  logic [3:0] money_code;
  logic       coin_reject;
  logic       jam;
  logic       busy;

  modport slave (
    input  coin_sensor,
    input  accept_en,
    output money_code,
    output coin_reject,
    output jam,
    output busy
  );

  modport master (
    output coin_sensor,
    output accept_en,
    input  money_code,
    input  coin_reject,
    input  jam,
    input  busy
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: measures the sensor pulse width, classifies the coin and emits
// a fixed-length one-hot money code or a return-gate pulse; flags a stuck sensor as jam.
module coin_acceptor #(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned T5         = 100,
  parameter int unsigned T10        = 200,
  parameter int unsigned T25        = 400,
  parameter int unsigned T100       = 800,
  parameter int unsigned TOL        = 20,
  parameter int unsigned T_JAM      = 2000,
  parameter int unsigned OUT_CYCLES = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  coin_acceptor_if.slave  bus
);

  localparam int unsigned PH_MAX = (OUT_CYCLES > GAP_CYCLES) ? OUT_CYCLES : GAP_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MEASURE  = 3'd1;
  localparam logic [2:0] S_CLASSIFY = 3'd2;
  localparam logic [2:0] S_EMIT     = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_JAM      = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] width, width_nxt;
  logic [PH_W-1:0]  ph, ph_nxt;
  logic [3:0]       money_code, money_code_nxt;
  logic             coin_reject, coin_reject_nxt;
  logic             jam, jam_nxt;
  logic             busy;

  logic             s_meta, s_sync, s_prev;
  logic             rise_c;
  logic [3:0]       match_c;

  // Synchroniser and edge history reset high so a sensor already high at release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= bus.coin_sensor;
      s_sync <= s_meta;
      s_prev <= s_sync;
    end
  end

  assign rise_c = s_sync & ~s_prev;

  function automatic logic in_win(input logic [CNT_W-1:0] w, input int unsigned t);
    return (w >= CNT_W'(t - TOL)) && (w <= CNT_W'(t + TOL));
  endfunction

  // Windows never overlap, so at most one bit is set.
  assign match_c = {in_win(width, T100), in_win(width, T25),
                    in_win(width, T10),  in_win(width, T5)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      width       <= '0;
      ph          <= '0;
      money_code  <= '0;
      coin_reject <= 1'b0;
      jam         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      width       <= width_nxt;
      ph          <= ph_nxt;
      money_code  <= money_code_nxt;
      coin_reject <= coin_reject_nxt;
      jam         <= jam_nxt;
      busy        <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt       = state;
    width_nxt       = width;
    ph_nxt          = ph;
    money_code_nxt  = money_code;
    coin_reject_nxt = coin_reject;
    jam_nxt         = jam;

    case (state)
      S_IDLE: begin
        if (rise_c) begin
          width_nxt = CNT_W'(1);
          state_nxt = S_MEASURE;
        end
      end

      S_MEASURE: begin
        if (s_sync) begin
          if (width == CNT_W'(T_JAM - 1)) begin
            width_nxt = CNT_W'(T_JAM);
            jam_nxt   = 1'b1;
            state_nxt = S_JAM;
          end else begin
            width_nxt = width + CNT_W'(1);
          end
        end else begin
          state_nxt = S_CLASSIFY;
        end
      end

      S_CLASSIFY: begin
        ph_nxt    = '0;
        state_nxt = S_EMIT;
        if (bus.accept_en && (match_c != 4'b0000)) begin
          money_code_nxt = match_c;
        end else begin
          coin_reject_nxt = 1'b1;
        end
      end

      // Outputs were loaded on entry; hold them OUT_CYCLES cycles then drop.
      S_EMIT: begin
        if (ph == PH_W'(OUT_CYCLES - 1)) begin
          money_code_nxt  = '0;
          coin_reject_nxt = 1'b0;
          ph_nxt          = '0;
          state_nxt       = S_GAP;
        end else begin
          ph_nxt = ph + PH_W'(1);
        end
      end

      // A sensor still high after the gap belongs to a pulse we never saw start.
      S_GAP: begin
        if (ph == PH_W'(GAP_CYCLES - 1)) begin
          if (!s_sync) begin
            state_nxt = S_IDLE;
          end
        end else begin
          ph_nxt = ph + PH_W'(1);
        end
      end

      S_JAM: begin
        if (!s_sync) begin
          jam_nxt   = 1'b0;
          ph_nxt    = '0;
          state_nxt = S_GAP;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.money_code  = money_code;
  assign bus.coin_reject = coin_reject;
  assign bus.jam         = jam;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: classification windows, accept gating, jam, gap and reset.
module tb_coin_acceptor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   out_cnt  = 0;
  int   both_cnt = 0;
  int   snap;

  coin_acceptor_if bus ();

  coin_acceptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Tracks any emitted output and any cycle where code and reject overlap.
  always @(negedge clk) begin
    if (bus.money_code != 4'b0000 || bus.coin_reject) out_cnt++;
    if (bus.money_code != 4'b0000 && bus.coin_reject) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  // Sensor sampled high at exactly n rising edges.
  task automatic pulse(input int n);
    bus.coin_sensor = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.coin_sensor = 1'b0;
  endtask

  // Called right after the sensor drops: nothing before edge k+3, then exactly 4 cycles.
  task automatic expect_emit(input string tag, input logic [3:0] code, input logic rej);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_pre_code"}, 32'(bus.money_code), 32'd0);
    chk({tag, "_pre_rej"}, 32'(bus.coin_reject), 32'd0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_code"}, 32'(bus.money_code), 32'(code));
      chk({tag, "_rej"}, 32'(bus.coin_reject), 32'(rej));
      @(posedge clk);
    end
    @(negedge clk);
    chk({tag, "_post_code"}, 32'(bus.money_code), 32'd0);
    chk({tag, "_post_rej"}, 32'(bus.coin_reject), 32'd0);
  endtask

  task automatic coin(input string tag, input int n, input logic [3:0] code, input logic rej);
    wait_idle({tag, "_idle"});
    pulse(n);
    expect_emit(tag, code, rej);
  endtask

  initial begin
    bus.coin_sensor = 1'b0;
    bus.accept_en   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_code", 32'(bus.money_code), 32'd0);
    chk("rst_rej", 32'(bus.coin_reject), 32'd0);
    chk("rst_jam", 32'(bus.jam), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Nominal 25 coin, then T10 window edges and rejects just outside / between windows.
    coin("c25", 400, 4'b0100, 1'b0);
    coin("c10_lo", 180, 4'b0010, 1'b0);
    coin("c10_hi", 220, 4'b0010, 1'b0);
    coin("r179", 179, 4'b0000, 1'b1);
    coin("r300", 300, 4'b0000, 1'b1);
    coin("r_short", 5, 4'b0000, 1'b1);

    // accept_en only matters in CLASSIFY.
    bus.accept_en = 1'b0;
    coin("dis100", 800, 4'b0000, 1'b1);
    wait_idle("tog1_idle");
    bus.coin_sensor = 1'b1;
    repeat (400) @(posedge clk);
    #1 bus.accept_en = 1'b1;
    repeat (400) @(posedge clk);
    #1 bus.coin_sensor = 1'b0;
    expect_emit("tog_on", 4'b1000, 1'b0);
    wait_idle("tog2_idle");
    bus.coin_sensor = 1'b1;
    repeat (400) @(posedge clk);
    #1 bus.accept_en = 1'b0;
    repeat (400) @(posedge clk);
    #1 bus.coin_sensor = 1'b0;
    expect_emit("tog_off", 4'b0000, 1'b1);
    bus.accept_en = 1'b1;

    // Jam: sensor stuck for 2500 cycles.
    wait_idle("jam_idle");
    snap = out_cnt;
    bus.coin_sensor = 1'b1;
    repeat (2001) @(posedge clk);
    @(negedge clk);
    chk("jam_early", 32'(bus.jam), 32'd0);
    chk("jam_busy0", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("jam_set", 32'(bus.jam), 32'd1);
    repeat (498) @(posedge clk);
    #1 bus.coin_sensor = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("jam_hold", 32'(bus.jam), 32'd1);
    chk("jam_busy1", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("jam_clr", 32'(bus.jam), 32'd0);
    chk("jam_busy2", 32'(bus.busy), 32'd1);
    wait_idle("jam_gap_idle");
    chk("jam_no_out", 32'(out_cnt - snap), 32'd0);
    coin("c5_after_jam", 100, 4'b0001, 1'b0);

    // Pulse starting inside GAP is ignored; one after GAP is measured.
    wait_idle("gap_idle");
    pulse(100);
    expect_emit("c5_a", 4'b0001, 1'b0);
    snap = out_cnt;
    bus.coin_sensor = 1'b1;
    repeat (100) @(posedge clk);
    #1 bus.coin_sensor = 1'b0;
    wait_idle("gap_skip_idle");
    repeat (10) @(negedge clk);
    chk("gap_skip_out", 32'(out_cnt - snap), 32'd0);
    chk("gap_skip_busy", 32'(bus.busy), 32'd0);
    coin("c5_b", 100, 4'b0001, 1'b0);

    // Reset during EMIT, released with the sensor high.
    wait_idle("rst_idle");
    pulse(400);
    repeat (4) @(posedge clk);
    #2;
    chk("rst_mid_pre", 32'(bus.money_code), 32'h4);
    rst = 1'b1;
    #1;
    chk("rst_mid_code", 32'(bus.money_code), 32'd0);
    chk("rst_mid_rej", 32'(bus.coin_reject), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    bus.coin_sensor = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    snap = out_cnt;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_hi_busy", 32'(bus.busy), 32'd0);
    bus.coin_sensor = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("rst_fall_busy", 32'(bus.busy), 32'd0);
    chk("rst_no_out", 32'(out_cnt - snap), 32'd0);
    coin("c25_fresh", 400, 4'b0100, 1'b0);

    wait_idle("end_idle");
    chk("never_both", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
